// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with registered results and a bit-serial shifter
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [2:0]       func,
    input  logic [WIDTH-1:0] inputa,
    input  logic [WIDTH-1:0] inputb,
    input  logic [AW-1:0]    amt,
    output logic [WIDTH-1:0] out,
    output logic             flag,
    output logic             overflow,
    output logic             branch_en,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_SW  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_CEQ = 3'd4;
    localparam logic [2:0] OP_CLT = 3'd5;
    localparam logic [2:0] OP_SEI = 3'd6;
    localparam logic [2:0] OP_O   = 3'd7;
    localparam logic [2:0] FN_B0  = 3'd6;
    localparam logic [2:0] FN_B1  = 3'd7;
    localparam logic [AW-1:0] AMT_MAX = AW'(WIDTH);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t        state;
    logic [AW-1:0] count;
    logic          shift_left;
    logic [1:0]    fill_sel;

    logic [AW-1:0]    amt_c;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             fill;
    logic [WIDTH-1:0] step_out;
    logic             step_ovf;
    logic             is_multi_shift;

    assign busy  = (state == SHIFT);
    assign amt_c = (amt > AMT_MAX) ? AMT_MAX : amt;
    assign sum   = {1'b0, inputa} + {1'b0, inputb} + (WIDTH+1)'(overflow);
    // Bit WIDTH of the widened difference is the borrow out.
    assign diff  = {1'b0, inputa} - {1'b0, inputb} - (WIDTH+1)'(overflow);
    assign is_multi_shift = (op == OP_O) && (func < FN_B0) && (amt_c != '0);

    always_comb begin
        fill     = 1'b0;
        step_out = out;
        step_ovf = overflow;
        case (fill_sel)
            2'd0:    fill = 1'b0;
            2'd1:    fill = flag;
            default: fill = overflow;
        endcase
        if (shift_left) begin
            step_out = {out[WIDTH-2:0], fill};
            step_ovf = out[WIDTH-1];
        end else begin
            step_out = {fill, out[WIDTH-1:1]};
            step_ovf = out[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            shift_left <= 1'b0;
            fill_sel   <= 2'd0;
            out        <= '0;
            flag       <= 1'b0;
            overflow   <= 1'b0;
            branch_en  <= 1'b0;
            done       <= 1'b0;
        end else begin
            done      <= 1'b0;
            branch_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_multi_shift) begin
                            out        <= inputa;
                            count      <= amt_c;
                            shift_left <= (func < 3'd3);
                            fill_sel   <= (func < 3'd3) ? func[1:0] : 2'(func - 3'd3);
                            state      <= SHIFT;
                        end else begin
                            done <= 1'b1;
                            case (op)
                                OP_LW, OP_SW: out <= inputb;
                                OP_ADD: {overflow, out} <= sum;
                                OP_SUB: begin
                                    out      <= diff[WIDTH-1:0];
                                    overflow <= diff[WIDTH];
                                end
                                OP_CEQ, OP_CLT: begin
                                    flag     <= (op == OP_CEQ) ? (inputa == inputb) : (inputa < inputb);
                                    out      <= '0;
                                    overflow <= 1'b0;
                                end
                                OP_SEI: out <= inputa;
                                default: begin
                                    // O-type reaching here is a branch or a zero-distance shift
                                    if (func == FN_B0 || func == FN_B1) begin
                                        branch_en <= (func == FN_B1) ? flag : ~flag;
                                        out       <= '0;
                                        overflow  <= 1'b0;
                                    end else begin
                                        out <= inputa;
                                    end
                                end
                            endcase
                        end
                    end
                end
                SHIFT: begin
                    out      <= step_out;
                    overflow <= step_ovf;
                    count    <= count - 1'b1;
                    if (count == AW'(1)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

    localparam int WIDTH = 8;
    localparam int AW    = $clog2(WIDTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [2:0]       op = '0;
    logic [2:0]       func = '0;
    logic [WIDTH-1:0] inputa = '0;
    logic [WIDTH-1:0] inputb = '0;
    logic [AW-1:0]    amt = '0;
    logic [WIDTH-1:0] out;
    logic             flag;
    logic             overflow;
    logic             branch_en;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;
    int cycles;

    alu_seq #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .func(func),
        .inputa(inputa), .inputb(inputb), .amt(amt), .out(out), .flag(flag),
        .overflow(overflow), .branch_en(branch_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, let the next edge accept it, and release start.
    task automatic issue(input logic [2:0] o, input logic [2:0] f, input logic [7:0] a,
                         input logic [7:0] b, input logic [AW-1:0] n);
        op = o; func = f; inputa = a; inputb = b; amt = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        tick();
        tick();
        check("reset_out", out, 0);
        check("reset_flag", flag, 0);
        check("reset_ovf", overflow, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_br", branch_en, 0);
        reset = 1'b0;

        issue(3'd2, 3'd0, 8'hFF, 8'h01, '0);
        check("add1_out", out, 8'h00);
        check("add1_ovf", overflow, 1);
        check("add1_done", done, 1);
        issue(3'd2, 3'd0, 8'h00, 8'h00, '0);
        check("add2_out", out, 8'h01);
        check("add2_ovf", overflow, 0);
        check("add2_done", done, 1);

        issue(3'd3, 3'd0, 8'h05, 8'h07, '0);
        check("sub_out", out, 8'hFE);
        check("sub_ovf", overflow, 1);
        issue(3'd5, 3'd0, 8'h03, 8'h09, '0);
        check("clt_flag", flag, 1);
        check("clt_out", out, 8'h00);
        check("clt_ovf", overflow, 0);

        issue(3'd0, 3'd0, 8'h12, 8'h77, '0);
        check("lw_out", out, 8'h77);
        check("lw_flag", flag, 1);
        tick();
        check("idle_done", done, 0);
        check("hold_out", out, 8'h77);

        issue(3'd7, 3'd2, 8'h81, 8'h00, AW'(3));
        check("shlo_busy0", busy, 1);
        check("shlo_done0", done, 0);
        op = 3'd2; inputa = 8'h01; inputb = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        check("shlo_busy1", busy, 1);
        wait_done(20, cycles);
        check("shlo_cycles", cycles + 1, 3);
        check("shlo_busy_end", busy, 0);
        check("shlo_out", out, 8'h0A);
        check("shlo_ovf", overflow, 0);
        check("shlo_flag", flag, 1);

        issue(3'd7, 3'd4, 8'h10, 8'h00, AW'(12));
        wait_done(20, cycles);
        check("shrf_cycles", cycles, 8);
        check("shrf_out", out, 8'hFF);
        check("shrf_ovf", overflow, 0);

        issue(3'd4, 3'd0, 8'h33, 8'h33, '0);
        check("ceq_flag", flag, 1);
        issue(3'd7, 3'd7, 8'h00, 8'h00, '0);
        check("b1_br", branch_en, 1);
        check("b1_done", done, 1);
        tick();
        check("b1_br_after", branch_en, 0);
        issue(3'd7, 3'd6, 8'h00, 8'h00, '0);
        check("b0_br", branch_en, 0);
        check("b0_done", done, 1);

        issue(3'd7, 3'd0, 8'h5A, 8'h00, '0);
        check("shl0_done", done, 1);
        check("shl0_busy", busy, 0);
        check("shl0_out", out, 8'h5A);

        issue(3'd7, 3'd0, 8'hFF, 8'h00, AW'(5));
        tick();
        check("rst_mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("abort_out", out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ovf", overflow, 0);
        check("abort_flag", flag, 0);
        reset = 1'b0;
        issue(3'd6, 3'd0, 8'h3C, 8'h00, '0);
        check("post_rst_out", out, 8'h3C);
        check("post_rst_done", done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
